// File: rtl/lockin_pkg.sv
// rtl/lockin_pkg.sv - shared widths and capture-state encoding for the lock-in datapath
package lockin_pkg;

  localparam int Q_signal = 16;
  localparam int Q_out_ca = 27;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } capture_state_t;

endpackage

// File: rtl/stream_frame_capture_if.sv
// rtl/stream_frame_capture_if.sv - sample stream, read port and status bundle of the frame capture
interface stream_frame_capture_if #(
  parameter int Q_in = 27,
  parameter int AW   = 7
);

  logic            arm;
  logic [Q_in-1:0] x;
  logic            x_valid;
  logic [AW-1:0]   rd_addr;
  logic            rd_en;
  logic [Q_in-1:0] rd_data;
  logic            rd_valid;
  logic            busy;
  logic            frame_done;
  logic [Q_in-1:0] x_min;
  logic [Q_in-1:0] x_max;
  logic [Q_in-1:0] p2p;
  logic [15:0]     overrun_cnt;

  modport master (
    output arm, x, x_valid, rd_addr, rd_en,
    input  rd_data, rd_valid, busy, frame_done, x_min, x_max, p2p, overrun_cnt
  );

  modport slave (
    input  arm, x, x_valid, rd_addr, rd_en,
    output rd_data, rd_valid, busy, frame_done, x_min, x_max, p2p, overrun_cnt
  );

endinterface

// File: rtl/frame_buffer_ram.sv
// rtl/frame_buffer_ram.sv - simple dual-port frame buffer with registered read data
module frame_buffer_ram #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 27,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is cleared; the array itself is left undefined by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/stream_frame_capture.sv
// rtl/stream_frame_capture.sv - captures one M-sample frame of the averaged stream with min/max/p2p tracking
module stream_frame_capture
  import lockin_pkg::*;
#(
  parameter int M    = 128,
  parameter int Q_in = Q_out_ca
) (
  input  logic                   clk,
  input  logic                   reset_n,
  stream_frame_capture_if.slave  bus
);

  localparam int            AW   = $clog2(M);
  localparam logic [AW-1:0] LAST = AW'(M - 1);

  capture_state_t  state, state_nxt;
  logic [AW-1:0]   wr_ptr, wr_ptr_nxt;
  logic            we;
  logic [AW-1:0]   waddr;
  logic            first_sample;
  logic            clr_ovr;
  logic            inc_ovr;
  logic [Q_in-1:0] x_min, x_max, p2p;
  logic [15:0]     overrun_cnt;
  logic            rd_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      wr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
    end
  end

  // arm has priority over a coincident sample in every state.
  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    we           = 1'b0;
    waddr        = wr_ptr;
    first_sample = 1'b0;
    clr_ovr      = 1'b0;
    inc_ovr      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.arm) begin
          state_nxt  = ARMED;
          wr_ptr_nxt = '0;
        end
      end
      ARMED: begin
        if (bus.arm) begin
          wr_ptr_nxt = '0;
        end else if (bus.x_valid) begin
          we           = 1'b1;
          waddr        = '0;
          first_sample = 1'b1;
          wr_ptr_nxt   = AW'(1);
          state_nxt    = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.arm) begin
          wr_ptr_nxt = '0;
          state_nxt  = ARMED;
        end else if (bus.x_valid) begin
          we = 1'b1;
          if (wr_ptr == LAST) begin
            wr_ptr_nxt = '0;
            state_nxt  = DONE;
          end else begin
            wr_ptr_nxt = wr_ptr + 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.arm) begin
          clr_ovr    = 1'b1;
          wr_ptr_nxt = '0;
          state_nxt  = ARMED;
        end else if (bus.x_valid) begin
          inc_ovr = 1'b1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        wr_ptr_nxt = '0;
      end
    endcase
  end

  // p2p lags x_min/x_max by one cycle; it settles the cycle after DONE is entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_min <= '0;
      x_max <= '0;
      p2p   <= '0;
    end else begin
      p2p <= x_max - x_min;
      if (we) begin
        if (first_sample || bus.x < x_min) begin
          x_min <= bus.x;
        end
        if (first_sample || bus.x > x_max) begin
          x_max <= bus.x;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_cnt <= '0;
      rd_valid    <= 1'b0;
    end else begin
      rd_valid <= bus.rd_en;
      if (clr_ovr) begin
        overrun_cnt <= '0;
      end else if (inc_ovr && overrun_cnt != 16'hFFFF) begin
        overrun_cnt <= overrun_cnt + 16'd1;
      end
    end
  end

  frame_buffer_ram #(
    .DEPTH (M),
    .WIDTH (Q_in),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (bus.x),
    .re      (bus.rd_en),
    .raddr   (bus.rd_addr),
    .rdata   (bus.rd_data)
  );

  assign bus.rd_valid    = rd_valid;
  assign bus.busy        = (state == ARMED) || (state == CAPTURE);
  assign bus.frame_done  = (state == DONE);
  assign bus.x_min       = x_min;
  assign bus.x_max       = x_max;
  assign bus.p2p         = p2p;
  assign bus.overrun_cnt = overrun_cnt;

endmodule

// File: tb/tb_stream_frame_capture.sv
// tb/tb_stream_frame_capture.sv - randomized and directed check of stream_frame_capture against a frame-level model
module tb_stream_frame_capture;

  localparam int M  = 128;
  localparam int Q  = 27;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  stream_frame_capture_if #(.Q_in(Q), .AW(AW)) bus ();

  stream_frame_capture #(.M(M), .Q_in(Q)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level model: a count of samples collected so far, plus bookkeeping flags.
  bit          m_collect, m_done;
  int          m_count;
  int          m_ovr;
  logic [Q-1:0] m_min, m_max, m_p2p;
  logic [Q-1:0] m_mem [M];
  bit           m_known [M];
  bit           m_rd_valid, m_rd_known;
  logic [Q-1:0] m_rd_data;

  function automatic void model_reset();
    m_collect = 0; m_done = 0; m_count = 0; m_ovr = 0;
    m_min = '0; m_max = '0; m_p2p = '0;
    m_rd_valid = 0; m_rd_data = '0; m_rd_known = 1;
    for (int i = 0; i < M; i++) m_known[i] = 0;
  endfunction

  function automatic void model_step(bit arm, bit xv, logic [Q-1:0] xs, bit re, int ra);
    m_rd_valid = re;
    if (re) begin
      m_rd_data  = m_mem[ra];
      m_rd_known = m_known[ra];
    end
    m_p2p = m_max - m_min;
    if (m_collect) begin
      if (arm) m_count = 0;
      else if (xv) begin
        m_mem[m_count]   = xs;
        m_known[m_count] = 1;
        if (m_count == 0) begin
          m_min = xs; m_max = xs;
        end else begin
          if (xs < m_min) m_min = xs;
          if (xs > m_max) m_max = xs;
        end
        m_count++;
        if (m_count == M) begin
          m_collect = 0; m_done = 1;
        end
      end
    end else if (m_done) begin
      if (arm) begin
        m_done = 0; m_collect = 1; m_count = 0; m_ovr = 0;
      end else if (xv && m_ovr < 65535) m_ovr++;
    end else if (arm) begin
      m_collect = 1; m_count = 0;
    end
  endfunction

  task automatic compare_all();
    expect_eq("busy", bus.busy, m_collect);
    expect_eq("frame_done", bus.frame_done, m_done);
    expect_eq("x_min", bus.x_min, m_min);
    expect_eq("x_max", bus.x_max, m_max);
    expect_eq("p2p", bus.p2p, m_p2p);
    expect_eq("overrun_cnt", bus.overrun_cnt, m_ovr);
    expect_eq("rd_valid", bus.rd_valid, m_rd_valid);
    if (m_rd_known) expect_eq("rd_data", bus.rd_data, m_rd_data);
  endtask

  task automatic tick(input bit arm, input bit xv, input logic [Q-1:0] xs, input bit re, input int ra);
    bus.arm     = arm;
    bus.x_valid = xv;
    bus.x       = xs;
    bus.rd_en   = re;
    bus.rd_addr = AW'(ra);
    @(posedge clk);
    model_step(arm, xv, xs, re, ra);
    #1;
    compare_all();
  endtask

  task automatic read_all();
    for (int i = 0; i < M; i++) tick(0, 0, '0, 1, i);
    tick(0, 0, '0, 0, 0);
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.arm     = 0;
    bus.x_valid = 0;
    bus.x       = '0;
    bus.rd_en   = 0;
    bus.rd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset_n = 1'b1;

    // 1: contiguous ramp
    tick(1, 0, '0, 0, 0);
    for (int i = 0; i < M; i++) begin
      tick(0, 1, Q'(i), 0, 0);
      if (i < M - 1) expect_eq("s1_busy_during", bus.busy, 1);
    end
    expect_eq("s1_done", bus.frame_done, 1);
    expect_eq("s1_min", bus.x_min, 0);
    expect_eq("s1_max", bus.x_max, 127);
    tick(0, 0, '0, 1, 5);
    expect_eq("s1_p2p", bus.p2p, 127);
    expect_eq("s1_rd5", bus.rd_data, 5);
    expect_eq("s1_rdv", bus.rd_valid, 1);
    tick(0, 0, '0, 0, 0);
    expect_eq("s1_rdv_drop", bus.rd_valid, 0);
    expect_eq("s1_rd_hold", bus.rd_data, 5);

    // 2: ramp with alternating valid
    tick(1, 0, '0, 0, 0);
    for (int i = 0; i < 2 * M - 1; i++) tick(0, (i % 2) == 0, Q'(i / 2), 0, 0);
    expect_eq("s2_done", bus.frame_done, 1);
    for (int i = 0; i < M; i++) begin
      tick(0, 0, '0, 1, i);
      expect_eq("s2_buf", bus.rd_data, i);
    end

    // 3: overrun in DONE, then re-arm
    for (int i = 0; i < 10; i++) tick(0, 1, Q'(9999), 0, 0);
    expect_eq("s3_ovr", bus.overrun_cnt, 10);
    read_all();
    tick(1, 0, '0, 0, 0);
    expect_eq("s3_ovr_clr", bus.overrun_cnt, 0);
    expect_eq("s3_busy", bus.busy, 1);

    // 4: partial frame abandoned by re-arm
    for (int i = 0; i < 40; i++) tick(0, 1, Q'(1000), 0, 0);
    tick(1, 0, '0, 0, 0);
    for (int i = 0; i < M; i++) tick(0, 1, Q'(7), 0, 0);
    tick(0, 0, '0, 0, 0);
    expect_eq("s4_min", bus.x_min, 7);
    expect_eq("s4_max", bus.x_max, 7);
    expect_eq("s4_p2p", bus.p2p, 0);
    for (int i = 0; i < M; i++) begin
      tick(0, 0, '0, 1, i);
      expect_eq("s4_buf", bus.rd_data, 7);
    end

    // 5: asynchronous reset mid-capture
    tick(1, 0, '0, 0, 0);
    for (int i = 0; i < 64; i++) tick(0, 1, Q'(i + 300), 1, i);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    expect_eq("s5_done", bus.frame_done, 0);
    expect_eq("s5_busy", bus.busy, 0);
    expect_eq("s5_min", bus.x_min, 0);
    expect_eq("s5_max", bus.x_max, 0);
    expect_eq("s5_p2p", bus.p2p, 0);
    expect_eq("s5_rdv", bus.rd_valid, 0);
    expect_eq("s5_rdd", bus.rd_data, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick(0, 1, Q'(77), 0, 0);
    expect_eq("s5_idle", bus.busy, 0);

    // 6: arm coincident with a valid sample
    tick(1, 1, Q'(55), 0, 0);
    tick(0, 1, Q'(3), 0, 0);
    tick(0, 0, '0, 1, 0);
    expect_eq("s6_buf0", bus.rd_data, 3);
    expect_eq("s6_min", bus.x_min, 3);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      tick($urandom_range(199) == 0, $urandom_range(9) < 7, Q'($urandom),
           $urandom_range(1), $urandom_range(M - 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
